// File: rtl/rob_alloc_ctrl.sv
// ROB allocation control: head/tail pointers, occupancy and post-flush recovery
// sequencing for the Data-in-ROB backend.
module rob_alloc_ctrl #(
   parameter int ROB_DEPTH      = 64,
   parameter int ROB_IDX_WIDTH  = $clog2(ROB_DEPTH),
   parameter int DISPATCH_WIDTH = 4,
   parameter int RECOVER_CYCLES = 2
) (
   input  logic                           clk_i,
   input  logic                           rst_ni,
   input  logic [DISPATCH_WIDTH-1:0]      dispatch_valid_i,
   input  logic [DISPATCH_WIDTH-1:0]      commit_valid_i,
   input  logic                           flush_i,
   output logic                           rob_ready_o,
   output logic [ROB_IDX_WIDTH-1:0]       rob_tail_ptr_o,
   output logic [ROB_IDX_WIDTH-1:0]       rob_head_ptr_o,
   output logic [$clog2(ROB_DEPTH+1)-1:0] rob_count_o,
   output logic                           rob_empty_o,
   output logic                           rob_full_o,
   output logic                           recovering_o
);

   localparam int CNT_W = $clog2(ROB_DEPTH + 1);
   localparam int GRP_W = $clog2(DISPATCH_WIDTH + 1);
   localparam int RC_W  = (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES) : 1;

   localparam logic [0:0] ST_NORMAL  = 1'b0;
   localparam logic [0:0] ST_RECOVER = 1'b1;

   localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(ROB_DEPTH - DISPATCH_WIDTH);
   localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(ROB_DEPTH);
   localparam logic [RC_W-1:0]  RC_LOAD   = RC_W'(RECOVER_CYCLES - 1);

   logic [ROB_IDX_WIDTH-1:0] head_q, tail_q;
   logic [CNT_W-1:0]         count_q;
   logic [0:0]               state_q;
   logic [RC_W-1:0]          rcnt_q;

   logic                     dispatch_ok;
   logic [GRP_W-1:0]         disp_raw, comm_raw;
   logic [GRP_W-1:0]         n_d, n_c;

   function automatic logic [GRP_W-1:0] popcnt(input logic [DISPATCH_WIDTH-1:0] v);
      logic [GRP_W-1:0] n;
      n = '0;
      for (int i = 0; i < DISPATCH_WIDTH; i++) n = n + GRP_W'(v[i]);
      return n;
   endfunction

   // Readiness is taken from registers only, so rename never sees a combinational
   // path from its own dispatch mask back into the ready signal.
   assign rob_ready_o    = (state_q == ST_NORMAL) && (count_q <= READY_MAX);
   assign rob_tail_ptr_o = tail_q;
   assign rob_head_ptr_o = head_q;
   assign rob_count_o    = count_q;
   assign rob_empty_o    = (count_q == '0);
   assign rob_full_o     = (count_q == DEPTH_C);
   assign recovering_o   = (state_q == ST_RECOVER);

   always_comb begin
      disp_raw    = popcnt(dispatch_valid_i);
      comm_raw    = popcnt(commit_valid_i);
      dispatch_ok = rob_ready_o && !flush_i;
      n_d         = dispatch_ok ? disp_raw : '0;
      n_c         = flush_i ? '0 : comm_raw;
   end

   // Flush wins over dispatch/commit; the recovery counter restarts on every flush.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         state_q <= ST_NORMAL;
         rcnt_q  <= '0;
      end else if (flush_i) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         state_q <= ST_RECOVER;
         rcnt_q  <= RC_LOAD;
      end else begin
         head_q  <= head_q + ROB_IDX_WIDTH'(n_c);
         tail_q  <= tail_q + ROB_IDX_WIDTH'(n_d);
         count_q <= count_q + CNT_W'(n_d) - CNT_W'(n_c);
         if (state_q == ST_RECOVER) begin
            if (rcnt_q == '0) state_q <= ST_NORMAL;
            else              rcnt_q  <= rcnt_q - 1'b1;
         end
      end
   end

   // Valid masks must be prefix-contiguous: adding one to the mask clears all its set bits.
   a_disp_prefix : assert property (@(posedge clk_i) disable iff (!rst_ni)
      (dispatch_valid_i & (dispatch_valid_i + 1'b1)) == '0);
   a_comm_prefix : assert property (@(posedge clk_i) disable iff (!rst_ni)
      (commit_valid_i & (commit_valid_i + 1'b1)) == '0);
   a_comm_count  : assert property (@(posedge clk_i) disable iff (!rst_ni)
      !flush_i |-> (CNT_W'(comm_raw) <= count_q));

endmodule

// File: tb/tb_rob_alloc_ctrl.sv
// Directed vector bench for rob_alloc_ctrl at ROB_DEPTH = 8.
module tb_rob_alloc_ctrl;

   localparam int DEPTH = 8;
   localparam int IDX_W = 3;
   localparam int CNT_W = 4;

   logic             clk_i = 1'b0;
   logic             rst_ni;
   logic [3:0]       dispatch_valid_i;
   logic [3:0]       commit_valid_i;
   logic             flush_i;
   logic             rob_ready_o;
   logic [IDX_W-1:0] rob_tail_ptr_o;
   logic [IDX_W-1:0] rob_head_ptr_o;
   logic [CNT_W-1:0] rob_count_o;
   logic             rob_empty_o;
   logic             rob_full_o;
   logic             recovering_o;

   int checks = 0;
   int errors = 0;

   rob_alloc_ctrl #(
      .ROB_DEPTH(DEPTH), .ROB_IDX_WIDTH(IDX_W), .DISPATCH_WIDTH(4), .RECOVER_CYCLES(2)
   ) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .dispatch_valid_i(dispatch_valid_i), .commit_valid_i(commit_valid_i),
      .flush_i(flush_i), .rob_ready_o(rob_ready_o),
      .rob_tail_ptr_o(rob_tail_ptr_o), .rob_head_ptr_o(rob_head_ptr_o),
      .rob_count_o(rob_count_o), .rob_empty_o(rob_empty_o),
      .rob_full_o(rob_full_o), .recovering_o(recovering_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [3:0] d;
      logic [3:0] c;
      logic       f;
      int         tail;
      int         head;
      int         cnt;
      int         rdy;
      int         emp;
      int         full;
      int         rec;
   } vec_t;

   vec_t vt[18];

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input int tail, input int head, input int cnt,
                          input int rdy, input int emp, input int full, input int rec);
      chk({tag, " tail"},  int'(rob_tail_ptr_o), tail);
      chk({tag, " head"},  int'(rob_head_ptr_o), head);
      chk({tag, " count"}, int'(rob_count_o),    cnt);
      chk({tag, " ready"}, int'(rob_ready_o),    rdy);
      chk({tag, " empty"}, int'(rob_empty_o),    emp);
      chk({tag, " full"},  int'(rob_full_o),     full);
      chk({tag, " recov"}, int'(recovering_o),   rec);
   endtask

   initial begin
      //           d      c      f     tail head cnt rdy emp full rec
      vt[0]  = '{4'h0, 4'h0, 1'b0, 0, 0, 0, 1, 1, 0, 0}; // idle
      vt[1]  = '{4'hF, 4'h0, 1'b0, 4, 0, 4, 1, 0, 0, 0}; // group 1
      vt[2]  = '{4'hF, 4'h0, 1'b0, 0, 0, 8, 0, 0, 1, 0}; // group 2, tail wraps
      vt[3]  = '{4'hF, 4'h0, 1'b0, 0, 0, 8, 0, 0, 1, 0}; // not ready: ignored
      vt[4]  = '{4'h0, 4'h3, 1'b0, 0, 2, 6, 0, 0, 0, 0};
      vt[5]  = '{4'h0, 4'h3, 1'b0, 0, 4, 4, 1, 0, 0, 0};
      vt[6]  = '{4'h3, 4'h3, 1'b0, 2, 6, 4, 1, 0, 0, 0};
      vt[7]  = '{4'h7, 4'h1, 1'b0, 5, 7, 6, 0, 0, 0, 0}; // simultaneous
      vt[8]  = '{4'h0, 4'h1, 1'b0, 5, 0, 5, 0, 0, 0, 0}; // head wraps
      vt[9]  = '{4'hF, 4'h1, 1'b1, 0, 0, 0, 0, 1, 0, 1}; // flush discards both
      vt[10] = '{4'h0, 4'h0, 1'b0, 0, 0, 0, 0, 1, 0, 1};
      vt[11] = '{4'h0, 4'h0, 1'b0, 0, 0, 0, 1, 1, 0, 0};
      vt[12] = '{4'hF, 4'h0, 1'b0, 4, 0, 4, 1, 0, 0, 0};
      vt[13] = '{4'h0, 4'h0, 1'b1, 0, 0, 0, 0, 1, 0, 1}; // flush
      vt[14] = '{4'h0, 4'h0, 1'b0, 0, 0, 0, 0, 1, 0, 1};
      vt[15] = '{4'h0, 4'h0, 1'b1, 0, 0, 0, 0, 1, 0, 1}; // reflush in 2nd cycle
      vt[16] = '{4'hF, 4'h0, 1'b0, 0, 0, 0, 0, 1, 0, 1}; // dispatch ignored
      vt[17] = '{4'h0, 4'h0, 1'b0, 0, 0, 0, 1, 1, 0, 0};

      rst_ni = 1'b0;
      dispatch_valid_i = '0;
      commit_valid_i = '0;
      flush_i = 1'b0;
      #3;
      chk_all("reset", 0, 0, 0, 1, 1, 0, 0);
      #9 rst_ni = 1'b1;

      for (int i = 0; i < 18; i++) begin
         dispatch_valid_i = vt[i].d;
         commit_valid_i   = vt[i].c;
         flush_i          = vt[i].f;
         @(posedge clk_i);
         #1;
         chk_all($sformatf("vec%0d", i), vt[i].tail, vt[i].head, vt[i].cnt,
                 vt[i].rdy, vt[i].emp, vt[i].full, vt[i].rec);
      end

      // async reset in the middle of recovery
      dispatch_valid_i = 4'hF; commit_valid_i = '0; flush_i = 1'b0;
      @(posedge clk_i); #1;
      chk_all("preflush", 4, 0, 4, 1, 0, 0, 0);
      dispatch_valid_i = '0; flush_i = 1'b1;
      @(posedge clk_i); #1;
      flush_i = 1'b0;
      chk_all("inrecov", 0, 0, 0, 0, 1, 0, 1);
      #2 rst_ni = 1'b0;
      #1;
      chk_all("rst_recov", 0, 0, 0, 1, 1, 0, 0);
      @(negedge clk_i) rst_ni = 1'b1;

      // async reset with pointers moved and a dispatch pending
      dispatch_valid_i = 4'h7;
      @(posedge clk_i); #1;
      chk_all("predisp", 3, 0, 3, 1, 0, 0, 0);
      commit_valid_i = 4'h1;
      #2 rst_ni = 1'b0;
      #1;
      chk_all("rst_disp", 0, 0, 0, 1, 1, 0, 0);
      dispatch_valid_i = '0; commit_valid_i = '0;
      @(negedge clk_i) rst_ni = 1'b1;
      @(posedge clk_i); #1;
      chk_all("postrst", 0, 0, 0, 1, 1, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
